// File: rtl/renode_apb3_pkg.sv
// Shared types and helpers for the Renode APB3 completer bridge.
`timescale 1ns/1ps
package renode_apb3_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam int unsigned StateBits = 3;

    // Number of low address bits that select a byte inside one data word.
    function automatic int unsigned byte_offset_bits(input int unsigned data_width);
        case (data_width)
            8:       return 0;
            16:      return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic is_apb_aligned(input logic [63:0] addr, input int unsigned data_width);
        logic [63:0] mask;
        mask = (64'd1 << byte_offset_bits(data_width)) - 64'd1;
        return (addr & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/renode_timeout_counter.sv
// Cycle counter that flags the last allowed cycle of a bounded wait; Limit=0 never expires.
`timescale 1ns/1ps
module renode_timeout_counter #(
    parameter int unsigned Limit = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CountWidth = (Limit < 2) ? 1 : $clog2(Limit + 1);
    localparam logic [CountWidth-1:0] LastCount = (Limit == 0) ? '0 : CountWidth'(Limit - 1);

    logic [CountWidth-1:0] count_q;
    logic [CountWidth-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CountWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted during the Limit-th enabled cycle so the owner leaves on that edge.
    assign expired_o = (Limit != 0) && enable_i && (count_q == LastCount);

endmodule

// File: rtl/renode_apb3_completer_bridge.sv
// APB3 completer that forwards each accepted transfer as one request/response on a valid/ready back end.
`timescale 1ns/1ps
module renode_apb3_completer_bridge
    import renode_apb3_pkg::*;
#(
    parameter int unsigned AddressWidth  = 20,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned BaseAddress   = 0,
    parameter int unsigned RegionSize    = 'h1000,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [AddressWidth-1:0] paddr,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DataWidth-1:0]    pwdata,
    output logic                    pready,
    output logic [DataWidth-1:0]    prdata,
    output logic                    pslverr,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic                    req_write,
    output logic [AddressWidth-1:0] req_addr,
    output logic [DataWidth-1:0]    req_wdata,
    input  logic                    rsp_valid,
    input  logic [DataWidth-1:0]    rsp_rdata,
    input  logic                    rsp_error,
    output logic [StateBits-1:0]    state_o
);

    localparam logic [AddressWidth-1:0] BaseAddr    = AddressWidth'(BaseAddress);
    localparam logic [AddressWidth:0]   RegionLimit = (AddressWidth + 1)'(RegionSize);

    // Handshake: req_valid rises after setup and stays high with stable req_* until
    // req_valid && req_ready; it only falls early on abort, timeout or reset.
    // rsp_valid is a one-cycle pulse and is only looked at in S_WAIT and S_DRAIN.

    state_t state_q, state_d;

    logic                    pready_q, pslverr_q, req_valid_q, req_write_q;
    logic [DataWidth-1:0]    prdata_q, req_wdata_q;
    logic [AddressWidth-1:0] req_addr_q;

    logic [AddressWidth-1:0] offset;
    logic                    decode_err;
    logic                    setup_accept;
    logic [DataWidth-1:0]    done_rdata;
    logic                    done_err;
    logic                    tmo_clear, tmo_enable, tmo_expired;

    assign offset     = paddr - BaseAddr;
    assign decode_err = (paddr < BaseAddr) || ({1'b0, offset} >= RegionLimit) ||
                        !is_apb_aligned(64'(paddr), DataWidth);

    assign tmo_clear  = (state_q == S_IDLE);
    assign tmo_enable = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN);

    renode_timeout_counter #(
        .Limit(TimeoutCycles)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (tmo_clear),
        .enable_i (tmo_enable),
        .expired_o(tmo_expired)
    );

    always_comb begin
        state_d      = state_q;
        setup_accept = 1'b0;
        done_rdata   = '0;
        done_err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (psel && !penable) begin
                    setup_accept = 1'b1;
                    if (decode_err) begin
                        state_d  = S_DONE;
                        done_err = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (!psel) begin
                    state_d = S_IDLE;
                end else if (tmo_expired) begin
                    state_d  = S_DONE;
                    done_err = 1'b1;
                end else if (req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    // The response is still owed by the back end; swallow it first.
                    state_d = (rsp_valid || tmo_expired) ? S_IDLE : S_DRAIN;
                end else if (rsp_valid) begin
                    state_d    = S_DONE;
                    done_rdata = req_write_q ? '0 : rsp_rdata;
                    done_err   = rsp_error;
                end else if (tmo_expired) begin
                    state_d  = S_DONE;
                    done_err = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (rsp_valid || tmo_expired) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pready_q    <= 1'b0;
            prdata_q    <= '0;
            pslverr_q   <= 1'b0;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pready_q    <= (state_d == S_DONE);
            prdata_q    <= (state_d == S_DONE) ? done_rdata : '0;
            pslverr_q   <= (state_d == S_DONE) ? done_err : 1'b0;
            req_valid_q <= (state_d == S_REQ);
            if (setup_accept) begin
                req_write_q <= pwrite;
                req_addr_q  <= offset;
                req_wdata_q <= pwdata;
            end
        end
    end

    assign pready    = pready_q;
    assign prdata    = prdata_q;
    assign pslverr   = pslverr_q;
    assign req_valid = req_valid_q;
    assign req_write = req_write_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_renode_apb3_completer_bridge.sv
// Directed bench for the APB3 completer bridge: window at 'h4000, 4 KiB, timeout of 8 cycles.
`timescale 1ns/1ps
module tb_renode_apb3_completer_bridge;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic [2:0]    state_o;

    int errors = 0;
    int checks = 0;

    renode_apb3_completer_bridge #(
        .AddressWidth (AW),
        .DataWidth    (DW),
        .BaseAddress  ('h4000),
        .RegionSize   ('h1000),
        .TimeoutCycles(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .state_o(state_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; rsp_error = 1'b0;
    endtask

    task automatic setup(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] data);
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data;
    endtask

    // Tests
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++; if (pready !== 1'b0) begin errors++; $display("FAIL reset_pready got=%b exp=0", pready); end
        checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata got=%h exp=0", prdata); end
        checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr got=%b exp=0", pslverr); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", req_valid); end
        checks++; if (req_write !== 1'b0) begin errors++; $display("FAIL reset_req_write got=%b exp=0", req_write); end
        checks++; if (req_addr !== 20'h0) begin errors++; $display("FAIL reset_req_addr got=%h exp=0", req_addr); end
        checks++; if (req_wdata !== 32'h0) begin errors++; $display("FAIL reset_req_wdata got=%h exp=0", req_wdata); end
        checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read();
        setup(20'h04004, 1'b0, 32'h0);
        req_ready = 1'b1;
        step();  // T1: S_REQ
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL read_req_valid got=%b exp=1", req_valid); end
        checks++; if (req_addr !== 20'h00004) begin errors++; $display("FAIL read_req_addr got=%h exp=00004", req_addr); end
        checks++; if (req_write !== 1'b0) begin errors++; $display("FAIL read_req_write got=%b exp=0", req_write); end
        checks++; if (pready !== 1'b0) begin errors++; $display("FAIL read_pready_t1 got=%b exp=0", pready); end
        penable = 1'b1;
        step();  // T2: S_WAIT
        checks++; if (pready !== 1'b0) begin errors++; $display("FAIL read_pready_t2 got=%b exp=0", pready); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL read_req_valid_t2 got=%b exp=0", req_valid); end
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'hDEADBEEF;
        step();  // T3: S_DONE
        rsp_valid = 1'b0; rsp_rdata = '0;
        checks++; if (pready !== 1'b1) begin errors++; $display("FAIL read_pready_t3 got=%b exp=1", pready); end
        checks++; if (prdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_prdata got=%h exp=deadbeef", prdata); end
        checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL read_pslverr got=%b exp=0", pslverr); end
        psel = 1'b0; penable = 1'b0;
        step();
        checks++; if (pready !== 1'b0 || prdata !== 32'h0) begin
            errors++; $display("FAIL read_after_done got pready=%b prdata=%h exp pready=0 prdata=0", pready, prdata);
        end
    endtask

    task automatic test_write_stall();
        setup(20'h04010, 1'b1, 32'h12345678);
        req_ready = 1'b0;
        step();  // T1: S_REQ
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (req_valid !== 1'b1 || req_addr !== 20'h00010 || req_wdata !== 32'h12345678 ||
                req_write !== 1'b1 || pready !== 1'b0) begin
                errors++;
                $display("FAIL write_stall_cycle%0d got valid=%b addr=%h wdata=%h write=%b pready=%b exp 1/00010/12345678/1/0",
                         i, req_valid, req_addr, req_wdata, req_write, pready);
            end
            penable = 1'b1;
            req_ready = (i == 4);
            step();
        end
        // now in S_WAIT
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL write_req_valid_wait got=%b exp=0", req_valid); end
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'hAAAA5555;
        step();  // S_DONE
        rsp_valid = 1'b0; rsp_rdata = '0;
        checks++; if (pready !== 1'b1) begin errors++; $display("FAIL write_pready got=%b exp=1", pready); end
        checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL write_prdata got=%h exp=0", prdata); end
        checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL write_pslverr got=%b exp=0", pslverr); end
        psel = 1'b0; penable = 1'b0;
        step();
    endtask

    task automatic test_decode_error();
        logic [AW-1:0] addrs [3];
        addrs[0] = 20'h05000;  // first address past the window
        addrs[1] = 20'h04002;  // misaligned
        addrs[2] = 20'h03FFC;  // below the window
        for (int i = 0; i < 3; i++) begin
            setup(addrs[i], 1'b0, 32'h0);
            req_ready = 1'b1;
            step();  // T1: S_DONE
            checks++;
            if (pready !== 1'b1 || pslverr !== 1'b1 || prdata !== 32'h0 || req_valid !== 1'b0) begin
                errors++;
                $display("FAIL decode_err_%0d got pready=%b pslverr=%b prdata=%h req_valid=%b exp 1/1/0/0",
                         i, pready, pslverr, prdata, req_valid);
            end
            penable = 1'b1;
            step();
            psel = 1'b0; penable = 1'b0; req_ready = 1'b0;
            checks++;
            if (pready !== 1'b0 || pslverr !== 1'b0 || req_valid !== 1'b0) begin
                errors++;
                $display("FAIL decode_err_after_%0d got pready=%b pslverr=%b req_valid=%b exp 0/0/0",
                         i, pready, pslverr, req_valid);
            end
            step();
        end
    endtask

    task automatic test_timeout();
        setup(20'h04008, 1'b0, 32'h0);
        req_ready = 1'b1;
        step();  // T1: S_REQ, accepted this cycle
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL timeout_req_valid got=%b exp=1", req_valid); end
        penable = 1'b1;
        for (int t = 2; t <= 8; t++) begin
            step();  // T2..T8: S_WAIT, no response
            req_ready = 1'b0;
            checks++;
            if (pready !== 1'b0 || req_valid !== 1'b0) begin
                errors++; $display("FAIL timeout_wait_t%0d got pready=%b req_valid=%b exp 0/0", t, pready, req_valid);
            end
        end
        step();  // T9: S_DONE
        checks++;
        if (pready !== 1'b1 || pslverr !== 1'b1 || prdata !== 32'h0 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_done got pready=%b pslverr=%b prdata=%h req_valid=%b exp 1/1/0/0",
                     pready, pslverr, prdata, req_valid);
        end
        psel = 1'b0; penable = 1'b0;
        step();
        rsp_valid = 1'b1; rsp_rdata = 32'h77777777;  // late response
        step();
        rsp_valid = 1'b0; rsp_rdata = '0;
        checks++;
        if (pready !== 1'b0 || prdata !== 32'h0 || state_o !== ST_IDLE) begin
            errors++; $display("FAIL timeout_late_rsp got pready=%b prdata=%h state=%0d exp 0/0/0", pready, prdata, state_o);
        end
    endtask

    task automatic test_abort_drain();
        setup(20'h0400C, 1'b0, 32'h0);
        req_ready = 1'b1;
        step();  // T1: S_REQ
        penable = 1'b1;
        step();  // T2: S_WAIT
        req_ready = 1'b0; psel = 1'b0; penable = 1'b0;
        step();  // T3: S_DRAIN
        checks++; if (state_o !== ST_DRAIN) begin errors++; $display("FAIL drain_enter got=%0d exp=4", state_o); end
        setup(20'h04020, 1'b0, 32'h0);
        for (int t = 3; t <= 5; t++) begin
            checks++;
            if (pready !== 1'b0 || req_valid !== 1'b0 || state_o !== ST_DRAIN) begin
                errors++; $display("FAIL drain_hold_t%0d got pready=%b req_valid=%b state=%0d exp 0/0/4",
                                   t, pready, req_valid, state_o);
            end
            if (t == 5) begin
                rsp_valid = 1'b1; rsp_rdata = 32'h11111111;
            end
            step();
        end
        rsp_valid = 1'b0; rsp_rdata = '0;
        checks++;
        if (state_o !== ST_IDLE || pready !== 1'b0 || prdata !== 32'h0) begin
            errors++; $display("FAIL drain_exit got state=%0d pready=%b prdata=%h exp 0/0/0", state_o, pready, prdata);
        end
        step();  // held setup now accepted
        checks++;
        if (state_o !== ST_REQ || req_valid !== 1'b1 || req_addr !== 20'h00020) begin
            errors++; $display("FAIL drain_next_setup got state=%0d req_valid=%b req_addr=%h exp 1/1/00020",
                               state_o, req_valid, req_addr);
        end
        penable = 1'b1; req_ready = 1'b1;
        step();
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'hCAFEF00D;
        step();
        rsp_valid = 1'b0; rsp_rdata = '0;
        checks++;
        if (pready !== 1'b1 || prdata !== 32'hCAFEF00D || pslverr !== 1'b0) begin
            errors++; $display("FAIL drain_next_read got pready=%b prdata=%h pslverr=%b exp 1/cafef00d/0",
                               pready, prdata, pslverr);
        end
        psel = 1'b0; penable = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        setup(20'h04004, 1'b1, 32'h99999999);
        req_ready = 1'b1;
        step();
        penable = 1'b1;
        step();  // S_WAIT
        req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pready !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0 || req_valid !== 1'b0 ||
            req_write !== 1'b0 || req_addr !== 20'h0 || req_wdata !== 32'h0 || state_o !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_mid got pready=%b prdata=%h pslverr=%b rv=%b rw=%b ra=%h rwd=%h state=%0d exp all 0",
                     pready, prdata, pslverr, req_valid, req_write, req_addr, req_wdata, state_o);
        end
        psel = 1'b0; penable = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        setup(20'h04018, 1'b0, 32'h0);
        req_ready = 1'b1;
        step();
        checks++; if (req_valid !== 1'b1 || req_addr !== 20'h00018) begin
            errors++; $display("FAIL reset_mid_req got valid=%b addr=%h exp 1/00018", req_valid, req_addr);
        end
        penable = 1'b1;
        step();
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'h0BADF00D;
        step();
        rsp_valid = 1'b0; rsp_rdata = '0;
        checks++;
        if (pready !== 1'b1 || prdata !== 32'h0BADF00D || pslverr !== 1'b0) begin
            errors++; $display("FAIL reset_mid_read got pready=%b prdata=%h pslverr=%b exp 1/0badf00d/0",
                               pready, prdata, pslverr);
        end
        psel = 1'b0; penable = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        setup(20'h04030, 1'b1, 32'h00000001);
        req_ready = 1'b1;
        step();
        penable = 1'b1;
        step();
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_error = 1'b1; rsp_rdata = 32'hFFFFFFFF;
        step();  // S_DONE with back-end error
        rsp_valid = 1'b0; rsp_error = 1'b0; rsp_rdata = '0;
        checks++;
        if (pready !== 1'b1 || pslverr !== 1'b1 || prdata !== 32'h0) begin
            errors++; $display("FAIL b2b_err_write got pready=%b pslverr=%b prdata=%h exp 1/1/0", pready, pslverr, prdata);
        end
        step();  // S_IDLE: next setup right away
        checks++;
        if (pready !== 1'b0 || pslverr !== 1'b0 || state_o !== ST_IDLE) begin
            errors++; $display("FAIL b2b_gap got pready=%b pslverr=%b state=%0d exp 0/0/0", pready, pslverr, state_o);
        end
        setup(20'h04034, 1'b0, 32'h0);
        req_ready = 1'b1;
        step();
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 20'h00034 || req_write !== 1'b0) begin
            errors++; $display("FAIL b2b_second_req got valid=%b addr=%h write=%b exp 1/00034/0", req_valid, req_addr, req_write);
        end
        penable = 1'b1;
        step();
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'h5A5A5A5A;
        step();
        rsp_valid = 1'b0; rsp_rdata = '0;
        checks++;
        if (pready !== 1'b1 || prdata !== 32'h5A5A5A5A || pslverr !== 1'b0) begin
            errors++; $display("FAIL b2b_second_read got pready=%b prdata=%h pslverr=%b exp 1/5a5a5a5a/0",
                               pready, prdata, pslverr);
        end
        psel = 1'b0; penable = 1'b0;
        step();
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_read();
        test_write_stall();
        test_decode_error();
        test_timeout();
        test_abort_drain();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
